// File: rtl/ntv_mtimer_if.sv
// rtl/ntv_mtimer_if.sv - native dmem-port bundle between the core and the machine timer
interface ntv_mtimer_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  r_en;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            byteenable;
  logic [31:0]           rdata;

  modport master (
    output r_en, w_en, addr, wdata, byteenable,
    input  rdata
  );

  modport slave (
    input  r_en, w_en, addr, wdata, byteenable,
    output rdata
  );
endinterface

// File: rtl/ntv_mtimer.sv
// rtl/ntv_mtimer.sv - RISC-V mtime/mtimecmp responder with prescaler, sticky status and level irq
module ntv_mtimer #(
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ntv_mtimer_if.slave    bus,
  output logic           timer_irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          pend_q, pend_d;
  logic          irq_q, irq_d;

  logic [2:0]    off;
  logic          hit;
  logic          tick;
  logic [31:0]   rd_val;
  logic          wr_lo, wr_hi;
  logic          unused_addr;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  assign off         = bus.addr[4:2];
  assign unused_addr = ^{bus.addr[ADDR_WIDTH-1:5], bus.addr[1:0]};
  assign hit         = (mtime_q >= cmp_q);
  assign tick        = ctrl_q[0] && (presc_q == PMAX);
  assign wr_lo       = bus.w_en && (off == OFF_MTIME_LO);
  assign wr_hi       = bus.w_en && (off == OFF_MTIME_HI);

  always_comb begin
    rd_val = 32'h0;
    case (off)
      OFF_MTIME_LO: rd_val = mtime_q[31:0];
      OFF_MTIME_HI: rd_val = shadow_q;
      OFF_CMP_LO:   rd_val = cmp_q[31:0];
      OFF_CMP_HI:   rd_val = cmp_q[63:32];
      OFF_CTRL:     rd_val = {30'h0, ctrl_q};
      OFF_STATUS:   rd_val = {31'h0, pend_q};
      default:      rd_val = 32'h0;
    endcase
  end

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    pend_d   = pend_q;
    irq_d    = ctrl_q[1] & hit;

    // Reads sample pre-write state so a same-cycle write to the same offset is not visible.
    if (bus.r_en) begin
      rdata_d = rd_val;
      if (off == OFF_MTIME_LO) shadow_d = mtime_q[63:32];
    end

    if (ctrl_q[0]) presc_d = tick ? '0 : presc_q + 1'b1;

    // A software write to either half owns mtime for this cycle; the tick is dropped.
    if (wr_lo || wr_hi) begin
      if (wr_lo) mtime_d[31:0]  = merge_lanes(mtime_q[31:0], bus.wdata, bus.byteenable);
      if (wr_hi) mtime_d[63:32] = merge_lanes(mtime_q[63:32], bus.wdata, bus.byteenable);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (bus.w_en) begin
      case (off)
        OFF_CMP_LO: cmp_d[31:0]  = merge_lanes(cmp_q[31:0], bus.wdata, bus.byteenable);
        OFF_CMP_HI: cmp_d[63:32] = merge_lanes(cmp_q[63:32], bus.wdata, bus.byteenable);
        OFF_CTRL:   if (bus.byteenable[0]) ctrl_d = bus.wdata[1:0];
        OFF_STATUS: if (bus.byteenable[0] && bus.wdata[0]) pend_d = 1'b0;
        default:    ;
      endcase
    end

    if (hit) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q  <= 64'h0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q <= 32'h0;
      rdata_q  <= 32'h0;
      ctrl_q   <= 2'b00;
      presc_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign timer_irq = irq_q;

endmodule
